// File: rtl/multi_pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator: mode encoding,
// default counter width and the width of the channel-select field.
package multi_pulse_gen_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_WIDTH = 26;
    localparam int unsigned LOAD_CH_W     = 4;

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: threshold register, counter, registered pulse and
// one-shot done flag. pulse_next is exposed so the top can register the OR.
module pulse_chan
    import multi_pulse_gen_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             pulse_next,
    output logic             pulse,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] thr;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] thr_next;
    logic [WIDTH-1:0] cnt_next;
    logic             done_next;
    logic             terminal;

    // thr is nonzero wherever terminal is used, so thr - 1 cannot wrap
    assign terminal = (cnt == (thr - ONE));

    always_comb begin
        thr_next   = thr;
        cnt_next   = cnt;
        done_next  = done;
        pulse_next = 1'b0;
        if (load) begin
            thr_next  = load_value;
            cnt_next  = '0;
            done_next = 1'b0;
        end else if (!enable) begin
            cnt_next  = '0;
            done_next = 1'b0;
        end else if (thr == '0) begin
            cnt_next = '0;
        end else if (done) begin
            cnt_next = '0;
            if (mode_e'(mode) == MODE_PERIODIC) begin
                done_next = 1'b0;
            end
        end else if (terminal) begin
            cnt_next   = '0;
            pulse_next = 1'b1;
            if (mode_e'(mode) == MODE_ONESHOT) begin
                done_next = 1'b1;
            end
        end else begin
            cnt_next = cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            thr   <= '0;
            cnt   <= '0;
            pulse <= 1'b0;
            done  <= 1'b0;
        end else begin
            thr   <= thr_next;
            cnt   <= cnt_next;
            pulse <= pulse_next;
            done  <= done_next;
        end
    end

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel pulse generator top: threshold-load decode, one pulse_chan
// per channel, and a registered OR of all channel pulses.
module multi_pulse_gen
    import multi_pulse_gen_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = DEFAULT_WIDTH
) (
    input  logic                 default_clk,
    input  logic                 resetn,
    input  logic [CHANNELS-1:0]  enable,
    input  logic [CHANNELS-1:0]  mode,
    input  logic                 load,
    input  logic [LOAD_CH_W-1:0] load_ch,
    input  logic [WIDTH-1:0]     load_value,
    output logic [CHANNELS-1:0]  pulse,
    output logic [CHANNELS-1:0]  done,
    output logic                 any_pulse
);

    logic [CHANNELS-1:0] pulse_next;

    // Indices at or above CHANNELS match no instance, so such loads are dropped
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        localparam logic [LOAD_CH_W-1:0] IDX = LOAD_CH_W'(i);

        pulse_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk        (default_clk),
            .resetn     (resetn),
            .enable     (enable[i]),
            .mode       (mode[i]),
            .load       (load && (load_ch == IDX)),
            .load_value (load_value),
            .pulse_next (pulse_next[i]),
            .pulse      (pulse[i]),
            .done       (done[i])
        );
    end

    always_ff @(posedge default_clk) begin
        if (!resetn) begin
            any_pulse <= 1'b0;
        end else begin
            any_pulse <= |pulse_next;
        end
    end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed bench for multi_pulse_gen (CHANNELS=4, WIDTH=4): a vector table
// for one-shot/mode/ignored-load behaviour plus hand-written timing sequences.
module tb_multi_pulse_gen;

    logic       default_clk;
    logic       resetn;
    logic [3:0] enable;
    logic [3:0] mode;
    logic       load;
    logic [3:0] load_ch;
    logic [3:0] load_value;
    logic [3:0] pulse;
    logic [3:0] done;
    logic       any_pulse;

    int unsigned errors;
    int unsigned checks;

    multi_pulse_gen #(
        .CHANNELS(4),
        .WIDTH(4)
    ) dut (
        .default_clk (default_clk),
        .resetn      (resetn),
        .enable      (enable),
        .mode        (mode),
        .load        (load),
        .load_ch     (load_ch),
        .load_value  (load_value),
        .pulse       (pulse),
        .done        (done),
        .any_pulse   (any_pulse)
    );

    initial default_clk = 1'b0;
    always #5 default_clk = ~default_clk;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] md;
        logic       ld;
        logic [3:0] ch;
        logic [3:0] val;
        logic [3:0] ep;
        logic [3:0] ed;
    } vec_t;

    vec_t tbl [17];

    task automatic step();
        @(posedge default_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] ep, input logic [3:0] ed);
        logic ea;
        ea = |ep;
        checks++;
        if (pulse !== ep || done !== ed || any_pulse !== ea) begin
            errors++;
            $display("FAIL %s: got pulse=%b done=%b any=%b, expected pulse=%b done=%b any=%b",
                     name, pulse, done, any_pulse, ep, ed, ea);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        enable = '0;
        mode   = '0;
        load   = 1'b0;
        step();
        check("reset", 4'b0000, 4'b0000);
        resetn = 1'b1;
    endtask

    task automatic load_t(input logic [3:0] ch, input logic [3:0] val);
        load       = 1'b1;
        load_ch    = ch;
        load_value = val;
        step();
        load       = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // en, md, ld, ch, val, expected pulse, expected done
        tbl[0]  = '{4'b0000, 4'b0010, 1'b1, 4'd1, 4'd3, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0010, 4'b0010, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0010, 4'b0010, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0010, 4'b0010, 1'b0, 4'd0, 4'd0, 4'b0010, 4'b0010};
        tbl[4]  = '{4'b0010, 4'b0010, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0010};
        tbl[5]  = '{4'b0010, 4'b0010, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0010};
        tbl[6]  = '{4'b0000, 4'b0010, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0010, 4'b0010, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0010, 4'b0010, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0010, 4'b0010, 1'b0, 4'd0, 4'd0, 4'b0010, 4'b0010};
        tbl[10] = '{4'b0010, 4'b0000, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0010, 4'b0000, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0010, 4'b0000, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0010, 4'b0000, 1'b0, 4'd0, 4'd0, 4'b0010, 4'b0000};
        tbl[14] = '{4'b1011, 4'b0000, 1'b1, 4'd7, 4'd1, 4'b0000, 4'b0000};
        tbl[15] = '{4'b1011, 4'b0000, 1'b0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[16] = '{4'b1011, 4'b0000, 1'b0, 4'd0, 4'd0, 4'b0010, 4'b0000};

        resetn     = 1'b0;
        enable     = '0;
        mode       = '0;
        load       = 1'b0;
        load_ch    = '0;
        load_value = '0;

        // reset must win over a concurrent load and enable
        enable     = 4'b1111;
        load       = 1'b1;
        load_ch    = 4'd0;
        load_value = 4'd1;
        step();
        check("reset_state", 4'b0000, 4'b0000);
        resetn = 1'b1;
        load   = 1'b0;
        enable = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("post_reset_%0d", k), 4'b0000, 4'b0000);
        end
        enable = '0;
        step();

        for (int i = 0; i < 17; i++) begin
            enable     = tbl[i].en;
            mode       = tbl[i].md;
            load       = tbl[i].ld;
            load_ch    = tbl[i].ch;
            load_value = tbl[i].val;
            step();
            check($sformatf("vec%0d", i), tbl[i].ep, tbl[i].ed);
        end
        load = 1'b0;

        do_reset();
        load_t(4'd0, 4'd5);
        enable = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("periodic5_%0d", k), (k % 5 == 0) ? 4'b0001 : 4'b0000, 4'b0000);
        end

        do_reset();
        load_t(4'd0, 4'd1);
        enable = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t1_%0d", k), 4'b0001, 4'b0000);
        end

        do_reset();
        enable = 4'b1111;
        for (int k = 1; k <= 50; k++) begin
            step();
            check($sformatf("t0_%0d", k), 4'b0000, 4'b0000);
        end

        do_reset();
        load_t(4'd2, 4'd15);
        enable = 4'b0100;
        for (int k = 1; k <= 30; k++) begin
            step();
            check($sformatf("tmax_%0d", k), (k % 15 == 0) ? 4'b0100 : 4'b0000, 4'b0000);
        end

        // reload on the terminal-count cycle suppresses that pulse
        do_reset();
        load_t(4'd2, 4'd4);
        enable = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("coll_pre_%0d", k), 4'b0000, 4'b0000);
        end
        load_t(4'd2, 4'd6);
        check("collision", 4'b0000, 4'b0000);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("coll_post_%0d", k), (k == 6) ? 4'b0100 : 4'b0000, 4'b0000);
        end

        do_reset();
        load_t(4'd0, 4'd8);
        enable = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("midrst_pre_%0d", k), 4'b0000, 4'b0000);
        end
        resetn     = 1'b0;
        load       = 1'b1;
        load_ch    = 4'd0;
        load_value = 4'd1;
        step();
        check("mid_reset", 4'b0000, 4'b0000);
        resetn = 1'b1;
        load   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("midrst_post_%0d", k), 4'b0000, 4'b0000);
        end
        enable = '0;
        load_t(4'd0, 4'd8);
        enable = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("midrst_reload_%0d", k), (k == 8) ? 4'b0001 : 4'b0000, 4'b0000);
        end

        do_reset();
        load_t(4'd3, 4'd4);
        enable = 4'b1000;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("gate_pre_%0d", k), 4'b0000, 4'b0000);
        end
        enable = 4'b0000;
        step();
        check("gate_drop", 4'b0000, 4'b0000);
        enable = 4'b1000;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("gate_post_%0d", k), (k % 4 == 0) ? 4'b1000 : 4'b0000, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
